// File: rtl/ntt_butterfly.sv
// Pipelined Cooley-Tukey NTT butterfly: a' = (a + w*b) mod q, b' = (a - w*b) mod q.
// Three register stages with a single global stall; the modulus (Kyber/Dilithium) travels with each operation.
module ntt_butterfly #(
    parameter int WIDTH       = 23,
    parameter int Q_KYBER     = 3329,
    parameter int Q_DILITHIUM = 8380417
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             select_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] w_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o
);

    localparam int PW = 2 * WIDTH;
    localparam int SW = WIDTH + 1;

    localparam logic [PW-1:0] QK_P = PW'(Q_KYBER);
    localparam logic [PW-1:0] QD_P = PW'(Q_DILITHIUM);
    localparam logic [SW-1:0] QK_S = SW'(Q_KYBER);
    localparam logic [SW-1:0] QD_S = SW'(Q_DILITHIUM);

    // Constant-divisor reductions for both moduli, selected afterwards.
    function automatic logic [WIDTH-1:0] mod_mul(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic             sel);
        logic [PW-1:0] p;
        logic [PW-1:0] rk;
        logic [PW-1:0] rd;
        p  = PW'(x) * PW'(y);
        rk = p % QK_P;
        rd = p % QD_P;
        return sel ? WIDTH'(rk) : WIDTH'(rd);
    endfunction

    function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic             sel);
        logic [SW-1:0] q;
        logic [SW-1:0] s;
        q = sel ? QK_S : QD_S;
        s = {1'b0, x} + {1'b0, y};
        return (s >= q) ? WIDTH'(s - q) : WIDTH'(s);
    endfunction

    function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic             sel);
        logic [SW-1:0] q;
        logic [SW-1:0] d;
        q = sel ? QK_S : QD_S;
        d = {1'b0, x} + q - {1'b0, y};
        return (x >= y) ? (x - y) : WIDTH'(d);
    endfunction

    logic             en;

    logic             vld_p1_q, vld_p1_d;
    logic             sel_p1_q, sel_p1_d;
    logic [WIDTH-1:0] a_p1_q, a_p1_d;
    logic [WIDTH-1:0] b_p1_q, b_p1_d;
    logic [WIDTH-1:0] w_p1_q, w_p1_d;

    logic             vld_p2_q, vld_p2_d;
    logic             sel_p2_q, sel_p2_d;
    logic [WIDTH-1:0] a_p2_q, a_p2_d;
    logic [WIDTH-1:0] t_p2_q, t_p2_d;

    logic             vld_p3_q, vld_p3_d;
    logic [WIDTH-1:0] a_p3_q, a_p3_d;
    logic [WIDTH-1:0] b_p3_q, b_p3_d;

    assign en      = !vld_p3_q || ready_i;
    assign ready_o = en;

    always_comb begin
        vld_p1_d = vld_p1_q;
        sel_p1_d = sel_p1_q;
        a_p1_d   = a_p1_q;
        b_p1_d   = b_p1_q;
        w_p1_d   = w_p1_q;
        vld_p2_d = vld_p2_q;
        sel_p2_d = sel_p2_q;
        a_p2_d   = a_p2_q;
        t_p2_d   = t_p2_q;
        vld_p3_d = vld_p3_q;
        a_p3_d   = a_p3_q;
        b_p3_d   = b_p3_q;
        if (en) begin
            // stage 1: capture operands
            vld_p1_d = valid_i;
            sel_p1_d = select_i;
            a_p1_d   = a_i;
            b_p1_d   = b_i;
            w_p1_d   = w_i;
            // stage 2: twiddle product
            vld_p2_d = vld_p1_q;
            sel_p2_d = sel_p1_q;
            a_p2_d   = a_p1_q;
            t_p2_d   = mod_mul(b_p1_q, w_p1_q, sel_p1_q);
            // stage 3: butterfly add/subtract
            vld_p3_d = vld_p2_q;
            a_p3_d   = mod_add(a_p2_q, t_p2_q, sel_p2_q);
            b_p3_d   = mod_sub(a_p2_q, t_p2_q, sel_p2_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_p1_q <= 1'b0;
            sel_p1_q <= 1'b0;
            a_p1_q   <= '0;
            b_p1_q   <= '0;
            w_p1_q   <= '0;
            vld_p2_q <= 1'b0;
            sel_p2_q <= 1'b0;
            a_p2_q   <= '0;
            t_p2_q   <= '0;
            vld_p3_q <= 1'b0;
            a_p3_q   <= '0;
            b_p3_q   <= '0;
        end else begin
            vld_p1_q <= vld_p1_d;
            sel_p1_q <= sel_p1_d;
            a_p1_q   <= a_p1_d;
            b_p1_q   <= b_p1_d;
            w_p1_q   <= w_p1_d;
            vld_p2_q <= vld_p2_d;
            sel_p2_q <= sel_p2_d;
            a_p2_q   <= a_p2_d;
            t_p2_q   <= t_p2_d;
            vld_p3_q <= vld_p3_d;
            a_p3_q   <= a_p3_d;
            b_p3_q   <= b_p3_d;
        end
    end

    assign valid_o = vld_p3_q;
    assign a_o     = a_p3_q;
    assign b_o     = b_p3_q;

endmodule

// File: tb/tb_ntt_butterfly.sv
// Directed bench for ntt_butterfly: table-driven single operations plus
// back-to-back, backpressure and asynchronous-reset sequences.
module tb_ntt_butterfly;

    localparam int WIDTH = 23;

    logic             clk_i = 1'b0;
    logic             rst_n_i;
    logic             valid_i;
    logic             ready_o;
    logic             select_i;
    logic [WIDTH-1:0] a_i, b_i, w_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] a_o, b_o;

    int checks = 0;
    int errors = 0;

    ntt_butterfly #(.WIDTH(WIDTH)) dut (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .select_i (select_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .w_i      (w_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .a_o      (a_o),
        .b_o      (b_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] w;
        logic [31:0] ea;
        logic [31:0] eb;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic drive(input int i);
        valid_i  = 1'b1;
        select_i = vecs[i].sel;
        a_i      = vecs[i].a[WIDTH-1:0];
        b_i      = vecs[i].b[WIDTH-1:0];
        w_i      = vecs[i].w[WIDTH-1:0];
    endtask

    task automatic idle();
        valid_i  = 1'b0;
        select_i = 1'b0;
        a_i      = '0;
        b_i      = '0;
        w_i      = '0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 100,     2,      3,       106,     94};
        vecs[1] = '{1'b1, 0,       'hEA1,  'h6C6,   2280,    1049};
        vecs[2] = '{1'b1, 3300,    100,    1,       71,      3200};
        vecs[3] = '{1'b0, 8380416, 1,      8380416, 8380415, 0};
        vecs[4] = '{1'b0, 1,       2,      3,       7,       8380412};

        rst_n_i = 1'b0;
        ready_i = 1'b1;
        idle();
        repeat (2) @(negedge clk_i);
        chk("reset valid_o", {31'b0, valid_o}, 0);
        chk("reset a_o", {9'b0, a_o}, 0);
        chk("reset b_o", {9'b0, b_o}, 0);
        chk("reset ready_o", {31'b0, ready_o}, 1);
        rst_n_i = 1'b1;
        step();
        chk("empty after reset", {31'b0, valid_o}, 0);

        // Single operations: 3-edge latency from acceptance.
        for (int i = 0; i < 5; i++) begin
            drive(i);
            step();
            idle();
            step();
            chk($sformatf("vec%0d early valid", i), {31'b0, valid_o}, 0);
            step();
            chk($sformatf("vec%0d valid_o", i), {31'b0, valid_o}, 1);
            chk($sformatf("vec%0d a_o", i), {9'b0, a_o}, vecs[i].ea);
            chk($sformatf("vec%0d b_o", i), {9'b0, b_o}, vecs[i].eb);
            if (vecs[i].sel)
                chk($sformatf("vec%0d kyber high bits", i), {20'b0, a_o[WIDTH-1:12] | b_o[WIDTH-1:12]}, 0);
            step();
            chk($sformatf("vec%0d valid drop", i), {31'b0, valid_o}, 0);
        end

        // Back-to-back, alternating modulus.
        for (int cyc = 0; cyc < 7; cyc++) begin
            int idx;
            int m;
            m = (cyc == 0) ? 0 : (cyc == 1) ? 3 : (cyc == 2) ? 1 : 4;
            if (cyc < 4) drive(m); else idle();
            step();
            idx = cyc - 2;
            if (idx >= 0 && idx < 4) begin
                m = (idx == 0) ? 0 : (idx == 1) ? 3 : (idx == 2) ? 1 : 4;
                chk($sformatf("b2b%0d valid", idx), {31'b0, valid_o}, 1);
                chk($sformatf("b2b%0d a_o", idx), {9'b0, a_o}, vecs[m].ea);
                chk($sformatf("b2b%0d b_o", idx), {9'b0, b_o}, vecs[m].eb);
            end else begin
                chk($sformatf("b2b cyc%0d idle", cyc), {31'b0, valid_o}, 0);
            end
        end

        // Backpressure: ready_i low for 8 cycles while offering 5 operations.
        begin
            int sent = 0;
            int recv = 0;
            bit acc, dlv;
            logic [WIDTH-1:0] ca, cb;
            for (int cyc = 0; cyc < 40 && recv < 5; cyc++) begin
                ready_i = (cyc >= 8);
                if (sent < 5) drive(sent); else idle();
                #1;
                if (cyc >= 3 && cyc < 8) begin
                    chk("stall ready_o", {31'b0, ready_o}, 0);
                    chk("stall valid_o", {31'b0, valid_o}, 1);
                    chk("stall a_o", {9'b0, a_o}, vecs[0].ea);
                    chk("stall b_o", {9'b0, b_o}, vecs[0].eb);
                    chk("stall accepted", sent, 3);
                end
                acc = valid_i && ready_o;
                dlv = valid_o && ready_i;
                ca  = a_o;
                cb  = b_o;
                @(posedge clk_i);
                if (acc) sent++;
                if (dlv) begin
                    chk($sformatf("bp%0d a_o", recv), {9'b0, ca}, vecs[recv].ea);
                    chk($sformatf("bp%0d b_o", recv), {9'b0, cb}, vecs[recv].eb);
                    recv++;
                end
                @(negedge clk_i);
            end
            chk("bp received", recv, 5);
            idle();
            step();
            chk("bp drained", {31'b0, valid_o}, 0);
        end

        // Asynchronous reset with operations in flight.
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(i);
            step();
        end
        idle();
        chk("pre-reset valid_o", {31'b0, valid_o}, 1);
        @(posedge clk_i);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("async reset valid_o", {31'b0, valid_o}, 0);
        chk("async reset a_o", {9'b0, a_o}, 0);
        chk("async reset b_o", {9'b0, b_o}, 0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        begin
            int stale = 0;
            for (int i = 0; i < 4; i++) begin
                step();
                if (valid_o) stale++;
            end
            chk("no stale results", stale, 0);
        end
        drive(2);
        step();
        idle();
        step();
        step();
        chk("post-reset valid_o", {31'b0, valid_o}, 1);
        chk("post-reset a_o", {9'b0, a_o}, vecs[2].ea);
        chk("post-reset b_o", {9'b0, b_o}, vecs[2].eb);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
